// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and FSM state encoding for the SPI initiator
package spi_pkg;

    // Only mode 0 is implemented: SCLK idles low, sample on rise, shift on fall
    localparam int SPI_MODE       = 0;
    localparam int DEFAULT_DATA_W = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_HIGH  = 3'd2;
    localparam logic [2:0] ST_LOW   = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - half-period counter producing a one-cycle tick every CLK_DIV cycles
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Combinational tick so the FSM leaves a phase on the edge ending its last cycle
    assign tick = en && (cnt == LAST);

    // Count 0..CLK_DIV-1 while enabled; restart on reset, frame acceptance or wrap
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 SPI initiator, one DATA_W frame per start request
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    output logic              ss
);

    localparam int BW = $clog2(DATA_W);
    localparam int GW = $clog2(CS_GAP + 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((CS_GAP > 0) ? CS_GAP - 1 : 0);

    logic [2:0]        state;
    logic [DATA_W-2:0] tx_shift;   // bits still to send; the current bit already sits on mosi
    logic [DATA_W-1:0] rx_shift;
    logic [BW-1:0]     bit_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              accept;
    logic              div_en;
    logic              tick;

    assign accept = (state == ST_IDLE) && start && !busy;
    assign div_en = (state != ST_IDLE) && (state != ST_GAP);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .en    (div_en),
        .tick  (tick)
    );

    // Frame sequencer: every phase except GAP advances on the divider tick
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ss       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        tx_shift <= tx_data[DATA_W-2:0];
                        mosi     <= tx_data[DATA_W-1];
                        ss       <= 1'b1;
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP, ST_LOW: begin
                    if (tick) begin
                        sclk     <= 1'b1;
                        rx_shift <= {rx_shift[DATA_W-2:0], miso};
                        state    <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (tick) begin
                        sclk <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            state <= ST_HOLD;
                        end else begin
                            mosi     <= tx_shift[DATA_W-2];
                            tx_shift <= tx_shift << 1;
                            bit_cnt  <= bit_cnt + 1'b1;
                            state    <= ST_LOW;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        ss      <= 1'b0;
                        mosi    <= 1'b0;
                        rx_data <= rx_shift;
                        done    <= 1'b1;
                        gap_cnt <= '0;
                        if (CS_GAP == 0) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
